// File: rtl/load_rs_queue_if.sv
// Handshake and bus bundle between dispatch/CDB/load-unit and the load reservation queue.
// Signals are named from the queue's point of view: i_* flow into the queue, o_* flow out of it.
// slave modport = queue side, master modport = surrounding pipeline (dispatch, CDB, load unit).
interface load_rs_queue_if #(
  parameter int DEPTH = 4,
  parameter int TAG_W = 4
);
  // dispatch
  logic                   i_disp_valid;
  logic                   o_disp_ready;
  logic [31:0]            i_disp_v1;
  logic [31:0]            i_disp_v2;
  logic                   i_disp_v1_valid;
  logic                   i_disp_v2_valid;
  logic [TAG_W-1:0]       i_disp_q1;
  logic [TAG_W-1:0]       i_disp_q2;
  logic [TAG_W-1:0]       i_disp_rd_tag;
  logic [2:0]             i_disp_mem_type;
  // squash
  logic                   i_flush;
  // common data bus snoop
  logic                   i_cdb_valid;
  logic [TAG_W-1:0]       i_cdb_tag;
  logic [31:0]            i_cdb_val;
  // head entry presented to the load unit
  logic [31:0]            o_v1;
  logic [31:0]            o_v2;
  logic                   o_v1_valid;
  logic                   o_v2_valid;
  logic [TAG_W-1:0]       o_rd_tag;
  logic [2:0]             o_mem_type;
  logic                   o_issue_valid;
  logic                   i_lu_complete;
  // occupancy
  logic [$clog2(DEPTH):0] o_count;

  modport slave (
    input  i_disp_valid, i_disp_v1, i_disp_v2, i_disp_v1_valid, i_disp_v2_valid,
           i_disp_q1, i_disp_q2, i_disp_rd_tag, i_disp_mem_type, i_flush,
           i_cdb_valid, i_cdb_tag, i_cdb_val, i_lu_complete,
    output o_disp_ready, o_v1, o_v2, o_v1_valid, o_v2_valid, o_rd_tag, o_mem_type,
           o_issue_valid, o_count
  );

  modport master (
    output i_disp_valid, i_disp_v1, i_disp_v2, i_disp_v1_valid, i_disp_v2_valid,
           i_disp_q1, i_disp_q2, i_disp_rd_tag, i_disp_mem_type, i_flush,
           i_cdb_valid, i_cdb_tag, i_cdb_val, i_lu_complete,
    input  o_disp_ready, o_v1, o_v2, o_v1_valid, o_v2_valid, o_rd_tag, o_mem_type,
           o_issue_valid, o_count
  );
endinterface

// File: rtl/load_rs_queue.sv
// In-order load reservation queue: holds dispatched loads, snoops the CDB for pending operands, issues head to the load unit.
// Latency: dispatch visible at head one cycle after push; CDB capture visible one cycle after broadcast; head view is combinational.
// Backpressure: o_disp_ready drops when all DEPTH entries are occupied, independent of same-cycle retire.
// Ports: i_clk, i_rst_n (async active-low), bus (slave modport: dispatch, flush, CDB, head/issue, lu_complete, count).
module load_rs_queue #(
  parameter int DEPTH = 4,
  parameter int TAG_W = 4
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  load_rs_queue_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic             busy;
    logic [31:0]      v1;
    logic             v1_valid;
    logic [TAG_W-1:0] q1;
    logic [31:0]      v2;
    logic             v2_valid;
    logic [TAG_W-1:0] q2;
    logic [TAG_W-1:0] rd_tag;
    logic [2:0]       mem_type;
  } entry_t;

  entry_t             r_ent [DEPTH];
  logic [PTR_W-1:0]   r_head;
  logic [PTR_W-1:0]   r_tail;
  logic [CNT_W-1:0]   r_count;

  entry_t             w_head;
  entry_t             w_new;
  logic               w_disp_ready;
  logic               w_push;
  logic               w_retire;

  assign w_head       = r_ent[r_head];
  assign w_disp_ready = (r_count < CNT_W'(DEPTH));
  assign w_push       = bus.i_disp_valid && w_disp_ready && !bus.i_flush;
  // Completion is only honoured for a fully-formed head; anything else is a stray pulse.
  assign w_retire     = bus.i_lu_complete && w_head.busy && w_head.v1_valid && w_head.v2_valid;

  // New entry, with same-cycle CDB bypass for operands still pending at dispatch.
  always_comb begin
    w_new          = '0;
    w_new.busy     = 1'b1;
    w_new.v1       = bus.i_disp_v1;
    w_new.v1_valid = bus.i_disp_v1_valid;
    w_new.q1       = bus.i_disp_q1;
    w_new.v2       = bus.i_disp_v2;
    w_new.v2_valid = bus.i_disp_v2_valid;
    w_new.q2       = bus.i_disp_q2;
    w_new.rd_tag   = bus.i_disp_rd_tag;
    w_new.mem_type = bus.i_disp_mem_type;
    if (!bus.i_disp_v1_valid && bus.i_cdb_valid && (bus.i_disp_q1 == bus.i_cdb_tag)) begin
      w_new.v1       = bus.i_cdb_val;
      w_new.v1_valid = 1'b1;
    end
    if (!bus.i_disp_v2_valid && bus.i_cdb_valid && (bus.i_disp_q2 == bus.i_cdb_tag)) begin
      w_new.v2       = bus.i_cdb_val;
      w_new.v2_valid = 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_ent[i] <= '0;
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (bus.i_flush) begin
      for (int i = 0; i < DEPTH; i++) r_ent[i] <= '0;
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      // Snoop: only pending operands of occupied entries listen to the CDB.
      if (bus.i_cdb_valid) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (r_ent[i].busy && !r_ent[i].v1_valid && (r_ent[i].q1 == bus.i_cdb_tag)) begin
            r_ent[i].v1       <= bus.i_cdb_val;
            r_ent[i].v1_valid <= 1'b1;
          end
          if (r_ent[i].busy && !r_ent[i].v2_valid && (r_ent[i].q2 == bus.i_cdb_tag)) begin
            r_ent[i].v2       <= bus.i_cdb_val;
            r_ent[i].v2_valid <= 1'b1;
          end
        end
      end
      // Retired head is wiped so an empty queue presents all-zero operands.
      if (w_retire) begin
        r_ent[r_head] <= '0;
        r_head        <= r_head + PTR_W'(1);
      end
      // Push slot is never busy (count < DEPTH), so it cannot collide with snoop or retire.
      if (w_push) begin
        r_ent[r_tail] <= w_new;
        r_tail        <= r_tail + PTR_W'(1);
      end
      case ({w_push, w_retire})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign bus.o_disp_ready  = w_disp_ready;
  assign bus.o_issue_valid = w_head.busy;
  assign bus.o_v1          = w_head.v1;
  assign bus.o_v2          = w_head.v2;
  assign bus.o_v1_valid    = w_head.busy && w_head.v1_valid;
  assign bus.o_v2_valid    = w_head.busy && w_head.v2_valid;
  assign bus.o_rd_tag      = w_head.rd_tag;
  assign bus.o_mem_type    = w_head.mem_type;
  assign bus.o_count       = r_count;
endmodule

// File: tb/tb_load_rs_queue.sv
module tb_load_rs_queue;
  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_fail;

  typedef struct {
    logic [31:0] v1;
    logic [31:0] v2;
    logic [3:0]  rd;
    logic [2:0]  mt;
  } exp_t;
  exp_t sb[$];

  load_rs_queue_if #(.DEPTH(4), .TAG_W(4)) bus ();
  load_rs_queue #(.DEPTH(4), .TAG_W(4)) dut (.i_clk(clk), .i_rst_n(rst_n), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.i_disp_valid    = 1'b0;
    bus.i_disp_v1       = '0;
    bus.i_disp_v2       = '0;
    bus.i_disp_v1_valid = 1'b0;
    bus.i_disp_v2_valid = 1'b0;
    bus.i_disp_q1       = '0;
    bus.i_disp_q2       = '0;
    bus.i_disp_rd_tag   = '0;
    bus.i_disp_mem_type = '0;
    bus.i_flush         = 1'b0;
    bus.i_cdb_valid     = 1'b0;
    bus.i_cdb_tag       = '0;
    bus.i_cdb_val       = '0;
    bus.i_lu_complete   = 1'b0;
  endtask

  // Drive dispatch fields; the expected head contents (after any CDB fill) go to the scoreboard.
  task automatic set_disp(input logic [31:0] v1, input logic v1v, input logic [3:0] q1,
                          input logic [31:0] v2, input logic v2v, input logic [3:0] q2,
                          input logic [3:0] rd, input logic [2:0] mt,
                          input logic [31:0] e1, input logic [31:0] e2, input bit expect_push);
    exp_t e;
    bus.i_disp_valid    = 1'b1;
    bus.i_disp_v1       = v1;
    bus.i_disp_v1_valid = v1v;
    bus.i_disp_q1       = q1;
    bus.i_disp_v2       = v2;
    bus.i_disp_v2_valid = v2v;
    bus.i_disp_q2       = q2;
    bus.i_disp_rd_tag   = rd;
    bus.i_disp_mem_type = mt;
    if (expect_push) begin
      e.v1 = e1; e.v2 = e2; e.rd = rd; e.mt = mt;
      sb.push_back(e);
    end
  endtask

  task automatic dispatch(input logic [31:0] v1, input logic [3:0] rd, input logic [2:0] mt);
    set_disp(v1, 1'b1, 4'd0, v1 + 32'h4, 1'b1, 4'd0, rd, mt, v1, v1 + 32'h4, 1'b1);
    tick();
    bus.i_disp_valid = 1'b0;
  endtask

  // Compare head against scoreboard front and pop it; lu_complete is raised for the next edge.
  task automatic check_head_and_pop(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      n_cmp++;
      n_fail++;
      $error("FAIL %s_sb_empty: observed 0 expected >0 entries", tag);
    end else begin
      e = sb.pop_front();
      chk({tag, "_issue_valid"}, {31'b0, bus.o_issue_valid}, 32'h1);
      chk({tag, "_v1"}, bus.o_v1, e.v1);
      chk({tag, "_v2"}, bus.o_v2, e.v2);
      chk({tag, "_v1_valid"}, {31'b0, bus.o_v1_valid}, 32'h1);
      chk({tag, "_v2_valid"}, {31'b0, bus.o_v2_valid}, 32'h1);
      chk({tag, "_rd_tag"}, {28'b0, bus.o_rd_tag}, {28'b0, e.rd});
      chk({tag, "_mem_type"}, {29'b0, bus.o_mem_type}, {29'b0, e.mt});
    end
    bus.i_lu_complete = 1'b1;
  endtask

  task automatic retire(input string tag);
    check_head_and_pop(tag);
    tick();
    bus.i_lu_complete = 1'b0;
  endtask

  task automatic check_empty(input string tag);
    chk({tag, "_count"}, {28'b0, bus.o_count}, 32'h0);
    chk({tag, "_issue_valid"}, {31'b0, bus.o_issue_valid}, 32'h0);
    chk({tag, "_disp_ready"}, {31'b0, bus.o_disp_ready}, 32'h1);
    chk({tag, "_v1_valid"}, {31'b0, bus.o_v1_valid}, 32'h0);
    chk({tag, "_v2_valid"}, {31'b0, bus.o_v2_valid}, 32'h0);
    chk({tag, "_v1"}, bus.o_v1, 32'h0);
    chk({tag, "_v2"}, bus.o_v2, 32'h0);
    chk({tag, "_rd_tag"}, {28'b0, bus.o_rd_tag}, 32'h0);
    chk({tag, "_mem_type"}, {29'b0, bus.o_mem_type}, 32'h0);
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    rst_n  = 1'b0;
    idle_inputs();
    tick();
    tick();
    check_empty("reset");
    rst_n = 1'b1;
    tick();

    // Basic dispatch of a fully-ready load, then retire.
    set_disp(32'h1000, 1'b1, 4'd0, 32'h8, 1'b1, 4'd0, 4'd3, 3'b010, 32'h1000, 32'h8, 1'b1);
    tick();
    bus.i_disp_valid = 1'b0;
    chk("basic_count", {28'b0, bus.o_count}, 32'h1);
    retire("basic");
    chk("basic_count_after", {28'b0, bus.o_count}, 32'h0);
    chk("basic_v1_valid_after", {31'b0, bus.o_v1_valid}, 32'h0);

    // Pending V1 captured from the CDB; later broadcasts leave it alone.
    set_disp(32'h0, 1'b0, 4'd5, 32'h4, 1'b1, 4'd0, 4'd6, 3'b100, 32'h2000, 32'h4, 1'b1);
    tick();
    bus.i_disp_valid = 1'b0;
    chk("pend_v1_valid_c1", {31'b0, bus.o_v1_valid}, 32'h0);
    bus.i_lu_complete = 1'b1;  // stray completion on an unready head is ignored
    tick();
    bus.i_lu_complete = 1'b0;
    chk("pend_stray_complete_count", {28'b0, bus.o_count}, 32'h1);
    chk("pend_v1_valid_c2", {31'b0, bus.o_v1_valid}, 32'h0);
    bus.i_cdb_valid = 1'b1; bus.i_cdb_tag = 4'd5; bus.i_cdb_val = 32'h2000;
    #1;
    chk("pend_v1_valid_bcast", {31'b0, bus.o_v1_valid}, 32'h0);
    tick();
    bus.i_cdb_valid = 1'b0;
    chk("pend_v1_captured", bus.o_v1, 32'h2000);
    chk("pend_v1_valid_after", {31'b0, bus.o_v1_valid}, 32'h1);
    bus.i_cdb_valid = 1'b1; bus.i_cdb_tag = 4'd5; bus.i_cdb_val = 32'hDEAD;
    tick();
    bus.i_cdb_valid = 1'b0;
    chk("pend_v1_no_overwrite", bus.o_v1, 32'h2000);
    retire("pend");

    // Same-cycle bypass of a pending V2.
    set_disp(32'h30, 1'b1, 4'd0, 32'h0, 1'b0, 4'd7, 4'd9, 3'b001, 32'h30, 32'h44, 1'b1);
    bus.i_cdb_valid = 1'b1; bus.i_cdb_tag = 4'd7; bus.i_cdb_val = 32'h44;
    tick();
    bus.i_disp_valid = 1'b0;
    bus.i_cdb_valid  = 1'b0;
    retire("bypass");

    // Fill, full backpressure with retire, wrap, in-order drain.
    for (int i = 0; i < 4; i++) dispatch(32'h100 * (i + 1), 4'(i + 1), 3'(i));
    chk("full_count", {28'b0, bus.o_count}, 32'h4);
    chk("full_disp_ready", {31'b0, bus.o_disp_ready}, 32'h0);
    set_disp(32'hBAD0, 1'b1, 4'd0, 32'hBAD4, 1'b1, 4'd0, 4'hF, 3'b111, 32'h0, 32'h0, 1'b0);
    check_head_and_pop("full_retire");
    tick();
    bus.i_disp_valid  = 1'b0;
    bus.i_lu_complete = 1'b0;
    chk("full_no_push_count", {28'b0, bus.o_count}, 32'h3);
    dispatch(32'h500, 4'd10, 3'b110);
    chk("wrap_count", {28'b0, bus.o_count}, 32'h4);
    for (int i = 0; i < 3; i++) retire("drain");
    chk("drain_count", {28'b0, bus.o_count}, 32'h1);
    // Push and retire in the same cycle keep the count.
    check_head_and_pop("pushret");
    set_disp(32'h600, 1'b1, 4'd0, 32'h604, 1'b1, 4'd0, 4'd11, 3'b011, 32'h600, 32'h604, 1'b1);
    tick();
    bus.i_disp_valid  = 1'b0;
    bus.i_lu_complete = 1'b0;
    chk("pushret_count", {28'b0, bus.o_count}, 32'h1);
    retire("pushret_last");
    chk("pushret_empty", {28'b0, bus.o_count}, 32'h0);

    // Flush wins over a simultaneous dispatch.
    for (int i = 0; i < 3; i++) dispatch(32'h700 + 32'(i), 4'(i), 3'b000);
    chk("preflush_count", {28'b0, bus.o_count}, 32'h3);
    set_disp(32'hF00, 1'b1, 4'd0, 32'hF04, 1'b1, 4'd0, 4'd2, 3'b010, 32'h0, 32'h0, 1'b0);
    bus.i_flush = 1'b1;
    tick();
    bus.i_flush      = 1'b0;
    bus.i_disp_valid = 1'b0;
    sb.delete();
    check_empty("flush");
    tick();
    chk("flush_stays_empty", {28'b0, bus.o_count}, 32'h0);

    // Asynchronous reset mid-cycle.
    dispatch(32'h800, 4'd4, 3'b010);
    dispatch(32'h900, 4'd5, 3'b010);
    chk("prereset_count", {28'b0, bus.o_count}, 32'h2);
    #2;
    rst_n = 1'b0;
    #1;
    sb.delete();
    check_empty("async_reset");
    tick();
    rst_n = 1'b1;
    tick();
    dispatch(32'hA00, 4'd12, 3'b101);
    chk("post_reset_count", {28'b0, bus.o_count}, 32'h1);
    retire("post_reset");
    chk("post_reset_empty", {28'b0, bus.o_count}, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
